// File: rtl/psram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psram_pkg
// Description : Shared types and constants for the PSRAM read-capture path.
// Revision    : 1.0 - initial release
// ============================================================================
package psram_pkg;

    localparam int PSRAM_WORD_W = 16;

    // {rwds_rise, rwds_fall} pattern that qualifies a read word
    localparam logic [1:0] RWDS_STROBE_VALID = 2'b10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LAT = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } psram_rd_state_t;

endpackage
`default_nettype wire

// File: rtl/psram_rd_timer.sv
`default_nettype none
// ============================================================================
// Module      : psram_rd_timer
// Description : Loadable down-counter, saturating at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_rd_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/psram_rd_capture.sv
`default_nettype none
// ============================================================================
// Module      : psram_rd_capture
// Description : Collects IDDR rise/fall sample pairs into 16-bit read words,
//               honouring initial latency, RWDS gating and burst length.
//               Optional CAPTURE watchdog enabled by PSRAM_RD_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_rd_capture
    import psram_pkg::*;
#(
    parameter int BURST_LEN   = 8,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    start,
    input  logic [3:0]              latency,
    input  logic [7:0]              dq_rise,
    input  logic [7:0]              dq_fall,
    input  logic                    rwds_rise,
    input  logic                    rwds_fall,
    output logic [PSRAM_WORD_W-1:0] rdata,
    output logic                    rdata_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    if (BURST_LEN < 2 || BURST_LEN > 255 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("psram_rd_capture: BURST_LEN or TIMEOUT_CYC out of range");
    end

    localparam logic [7:0] c_last_idx = 8'(BURST_LEN - 1);

    psram_rd_state_t         r_state;
    psram_rd_state_t         w_state_nxt;
    logic [7:0]              r_word_cnt;
    logic [3:0]              w_lat_cnt;
    logic                    w_start_ok;
    logic                    w_strobe;
    logic                    w_last_word;
    logic                    w_timeout;
    logic [PSRAM_WORD_W-1:0] r_rdata;
    logic                    r_rdata_valid;
    logic                    r_error;

    assign w_start_ok  = start && (r_state == IDLE);
    assign w_strobe    = (r_state == CAPTURE) &&
                         ({rwds_rise, rwds_fall} == RWDS_STROBE_VALID);
    assign w_last_word = w_strobe && (r_word_cnt == c_last_idx);

    psram_rd_timer #(
        .WIDTH (4)
    ) u_lat_timer (
        .clk        (clk),
        .n_reset    (n_reset),
        .i_load     (w_start_ok),
        .i_load_val (latency),
        .i_dec      (r_state == WAIT_LAT),
        .o_count    (w_lat_cnt)
    );

`ifdef PSRAM_RD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] w_wd_cnt;

    // Reloaded outside CAPTURE and on every strobe; counts strobe-less cycles
    psram_rd_timer #(
        .WIDTH (WD_W)
    ) u_wd_timer (
        .clk        (clk),
        .n_reset    (n_reset),
        .i_load     ((r_state != CAPTURE) || w_strobe),
        .i_load_val (WD_W'(TIMEOUT_CYC)),
        .i_dec      (r_state == CAPTURE),
        .o_count    (w_wd_cnt)
    );

    assign w_timeout = (r_state == CAPTURE) && !w_strobe && (w_wd_cnt == WD_W'(1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (latency != 4'd0) ? WAIT_LAT : CAPTURE;
                end
            end
            WAIT_LAT: begin
                if (w_lat_cnt == 4'd1) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (w_last_word) begin
                    w_state_nxt = DONE;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // Word assembly: one register stage from strobe to rdata_valid
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_word_cnt    <= '0;
            r_error       <= 1'b0;
        end else begin
            r_rdata_valid <= w_strobe;
            r_error       <= w_timeout;
            if (w_strobe) begin
                r_rdata <= {dq_rise, dq_fall};
            end
            if (w_start_ok) begin
                r_word_cnt <= '0;
            end else if (w_strobe) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_psram_rd_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_psram_rd_capture
// Description : Directed self-checking bench for psram_rd_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psram_rd_capture;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start;
    logic [3:0]  latency;
    logic [7:0]  dq_rise;
    logic [7:0]  dq_fall;
    logic        rwds_rise;
    logic        rwds_fall;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        done;
    logic        error;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_done_p;
    int          n_err_p;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    psram_rd_capture u_dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .start       (start),
        .latency     (latency),
        .dq_rise     (dq_rise),
        .dq_fall     (dq_fall),
        .rwds_rise   (rwds_rise),
        .rwds_fall   (rwds_fall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and record output pulses
    task automatic step();
        @(posedge clk);
        #1;
        if (rdata_valid) got_q.push_back(rdata);
        if (done)  n_done_p++;
        if (error) n_err_p++;
    endtask

    function automatic logic [15:0] word_of(input int j);
        return {8'(17 + 34 * j), 8'(34 + 34 * j)};
    endfunction

    // Continuous strobes from the start cycle; strobes before CAPTURE carry 16'hAABB
    task automatic run_burst(input logic [3:0] lat, input string tag);
        int j;
        got_q.delete();
        n_done_p = 0;
        start    = 1'b1;
        latency  = lat;
        for (int k = 0; k <= int'(lat) + 8; k++) begin
            if (k > 0) start = 1'b0;
            j = k - (int'(lat) + 1);
            rwds_rise = 1'b1;
            rwds_fall = 1'b0;
            {dq_rise, dq_fall} = (j >= 0) ? word_of(j) : 16'hAABB;
            step();
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_valid"}, rdata_valid, (j >= 0));
            if (j >= 0) chk({tag, "_rdata"}, rdata, word_of(j));
            chk({tag, "_done"}, done, (k == int'(lat) + 8));
        end
        rwds_rise = 1'b0;
        step();
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_done_end"}, done, 0);
        chk({tag, "_ndone"}, n_done_p, 1);
    endtask

    logic [1:0] pat [15] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 2'b11,
                            2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10};

    initial begin
        n_reset = 1'b0;
        start = 1'b0; latency = 4'd0;
        dq_rise = 8'h00; dq_fall = 8'h00;
        rwds_rise = 1'b0; rwds_fall = 1'b0;
        n_done_p = 0; n_err_p = 0;

        // Reset state
        step(); step();
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_valid", rdata_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        n_reset = 1'b1;
        step();

        // Latency 3, first word 16'h1122 five cycles after start
        run_burst(4'd3, "lat3");

        // Async reset after 3 words of a burst
        start = 1'b1; latency = 4'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rwds_rise = 1'b1; rwds_fall = 1'b0;
            {dq_rise, dq_fall} = 16'h5A00 + 16'(i);
            step();
        end
        rwds_rise = 1'b0;
        chk("pre_rst_valid", rdata_valid, 1);
        chk("pre_rst_rdata", rdata, 16'h5A02);
        #2 n_reset = 1'b0;
        #1;
        chk("arst_rdata", rdata, 16'h0000);
        chk("arst_valid", rdata_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_error", error, 0);
        #2 n_reset = 1'b1;
        run_burst(4'd2, "post_rst");

        // Latency 0 with interleaved non-strobe RWDS patterns
        got_q.delete(); exp_q.delete(); n_done_p = 0;
        start = 1'b1; latency = 4'd0; rwds_rise = 1'b0; rwds_fall = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            {rwds_rise, rwds_fall} = pat[i];
            dq_rise = 8'(8'hA0 + i);
            dq_fall = 8'(8'h50 + i);
            if (pat[i] == 2'b10) exp_q.push_back({dq_rise, dq_fall});
            step();
            chk("gap_valid", rdata_valid, (pat[i] == 2'b10));
        end
        {rwds_rise, rwds_fall} = 2'b00;
        step();
        chk("gap_nwords", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk("gap_word", got_q[i], exp_q[i]);
        chk("gap_ndone", n_done_p, 1);
        chk("gap_busy_end", busy, 0);

        // start re-pulsed mid-CAPTURE must be ignored
        got_q.delete(); exp_q.delete(); n_done_p = 0;
        start = 1'b1; latency = 4'd1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) start = (k == 5);
            if (k == 5) latency = 4'hF;
            rwds_rise = 1'b1; rwds_fall = 1'b0;
            dq_rise = 8'(k);
            dq_fall = 8'(8'hF0 ^ k);
            if (k >= 2) exp_q.push_back({dq_rise, dq_fall});
            step();
            chk("restart_done", done, (k == 9));
        end
        start = 1'b0; rwds_rise = 1'b0;
        step();
        chk("restart_busy_end", busy, 0);
        chk("restart_nwords", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk("restart_word", got_q[i], exp_q[i]);
        chk("restart_ndone", n_done_p, 1);

        // Strobes stop after 5 words
        got_q.delete(); n_done_p = 0; n_err_p = 0;
        start = 1'b1; latency = 4'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rwds_rise = 1'b1; rwds_fall = 1'b0;
            {dq_rise, dq_fall} = 16'hC000 + 16'(i);
            step();
        end
        rwds_rise = 1'b0;
        for (int i = 0; i < 40; i++) step();
        chk("stall_nwords", got_q.size(), 5);
        chk("stall_ndone", n_done_p, 0);
`ifdef PSRAM_RD_TIMEOUT_EN
        chk("stall_nerror", n_err_p, 1);
        chk("stall_busy", busy, 0);
`else
        chk("stall_nerror", n_err_p, 0);
        chk("stall_busy", busy, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/psram_rd_capture.md
Name: psram_rd_capture

Overview:
- Read-side data collector for the PSRAM controller; receive-direction counterpart of the ODDR-driven command/write path.
- Takes per-clock DDR sample pairs already split by the input DDR primitive (rise/fall bytes plus rise/fall RWDS) and assembles them into 16-bit read words.
- Counts the initial latency, gates words with the RWDS strobe, and terminates after a fixed burst length.
- Sits between the IDDR input stage and the PSRAM controller read-response logic.

Parameters:
- BURST_LEN, 8, words per read burst (2..255).
- TIMEOUT_CYC, 32, idle clk cycles tolerated in CAPTURE without a strobe (only with the optional feature).

Ports:
- clk  in  1  system clock; single clock domain.
- n_reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a read burst; honoured only in IDLE.
- latency  in  4  cycles to wait after start before strobes are accepted; sampled on start.
- dq_rise  in  8  DQ byte sampled on the rising edge (high byte of the word).
- dq_fall  in  8  DQ byte sampled on the falling edge (low byte of the word).
- rwds_rise  in  1  RWDS sampled on the rising edge.
- rwds_fall  in  1  RWDS sampled on the falling edge.
- rdata  out  16  assembled read word.
- rdata_valid  out  1  one-cycle qualifier for rdata.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the burst completes.
- error  out  1  one-cycle pulse on timeout abort; tied 0 without the optional feature.

Behaviour:
- Reset values (asynchronous, while n_reset = 0): state = IDLE, rdata = 16'h0000, rdata_valid = 0, busy = 0, done = 0, error = 0, all counters = 0.
- State machine: IDLE, WAIT_LAT, CAPTURE, DONE.
- IDLE:
  - start = 1 with latency > 0: load lat_cnt = latency, go to WAIT_LAT.
  - start = 1 with latency = 0: go directly to CAPTURE.
  - In both cases clear word_cnt.
- WAIT_LAT:
  - lat_cnt decrements every cycle; strobes seen here are ignored.
  - When lat_cnt = 1, go to CAPTURE. Latency N gives exactly N WAIT_LAT cycles.
- CAPTURE: a valid strobe is rwds_rise = 1 and rwds_fall = 0.
  - On a valid strobe, the next cycle has rdata = {dq_rise, dq_fall} and rdata_valid = 1. Latency is one register stage, and the word count increments.
  - Any other RWDS pattern (00, 11, 01) is ignored; no word is produced.
  - The strobe that brings word_cnt to BURST_LEN moves the FSM to DONE. That final word is still presented, in the same cycle the FSM enters DONE.
- DONE: asserts done = 1 for exactly one cycle, then returns to IDLE. busy stays 1 in this state.
- start while busy = 1 is ignored and has no side effects.
- Back-to-back bursts: start is accepted on the first IDLE cycle after DONE. Minimum gap is done pulse, then 1 cycle.
- rdata holds its last value when rdata_valid = 0.
- word_cnt is 8 bits wide and cannot wrap, because completion occurs at BURST_LEN.
- Reset mid-burst aborts immediately to the reset values. No done or error pulse is produced.

Optional Feature:
- Macro: PSRAM_RD_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in CAPTURE and clears on every valid strobe.
  - When it reaches TIMEOUT_CYC, error pulses for 1 cycle and the FSM returns to IDLE, skipping DONE. No done pulse is issued.
  - Words already delivered stand.
- Not defined:
  - No watchdog; CAPTURE waits indefinitely.
  - error is tied to 0; TIMEOUT_CYC is unused.

Decomposition:
- Shared package psram_pkg holds:
  - the state enum type psram_rd_state_t (IDLE, WAIT_LAT, CAPTURE, DONE);
  - the localparam PSRAM_WORD_W = 16;
  - the strobe-valid pattern constant 2'b10 (rise, fall).
- One natural sub-module: psram_rd_timer, a loadable down-counter used for the latency countdown and reused for the watchdog.
- Word assembly and the FSM remain in the top module.

Test Plan:
1. Reset while busy:
   - n_reset = 0 asserted in CAPTURE after 3 words -> all outputs return to 0 asynchronously.
   - After release, a new start with latency = 2 works normally and yields 8 words plus done.
2. latency = 3, BURST_LEN = 8, valid strobes every cycle with dq_rise/dq_fall = 8'h11/8'h22, 8'h33/8'h44, and so on:
   - A strobe during WAIT_LAT produces no output.
   - The first rdata_valid appears 3 + 2 cycles after start, with rdata = 16'h1122.
   - 8 consecutive words, then done = 1 for one cycle; busy falls the following cycle.
3. latency = 0, strobes with gaps and RWDS patterns 11 / 01 / 00 interleaved:
   - Only 2'b10 cycles produce words.
   - Exactly 8 valid pulses, with rdata order matching strobe order.
4. start pulsed again mid-CAPTURE:
   - Ignored: word count, latency and data are unaffected.
   - done occurs after the original 8th word.
5. Timeout, with PSRAM_RD_TIMEOUT_EN defined and TIMEOUT_CYC = 32:
   - 5 strobes, then none for 32 cycles -> error pulses for 1 cycle, done never asserts, busy = 0 the next cycle.
   - Without the macro: same stimulus keeps busy = 1 indefinitely, with error = 0.
